// File: rtl/mem_access_pkg.sv
// ----------------------------------------------------------------------------
// mem_access_pkg
// Shared types and constants for the load/store controller:
//   - WORD_SIZE / ADDR_SIZE : data and address widths (16-bit word memory)
//   - state_t               : controller FSM encoding (IDLE/READ/WRITE/RESP)
//   - LANE_HI / LANE_LO     : byte-lane select, big-endian within a word
//   - req_t                 : request fields latched on acceptance
// ----------------------------------------------------------------------------
package mem_access_pkg;

    localparam int WORD_SIZE = 16;
    localparam int ADDR_SIZE = 16;
    localparam int BYTE_SIZE = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Big-endian: byte address bit 0 = 0 picks the upper half of the word.
    localparam logic LANE_HI = 1'b0;
    localparam logic LANE_LO = 1'b1;

    // Only the fields still needed after acceptance are kept; the word
    // address and halfword store data go straight into the memory-side
    // registers when the request is taken.
    typedef struct packed {
        logic                 is_write;
        logic                 is_byte;
        logic                 is_signed;
        logic                 lane;
        logic [BYTE_SIZE-1:0] wbyte;
    } req_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl_if
// Pipeline-side request/response bundle of the load/store controller.
//   master : MEM stage (drives requests, receives responses)
//   slave  : mem_access_ctrl
// Signals: req_valid/req_ready handshake, req_write, req_byte, req_signed,
//          req_addr (byte address), req_wdata, resp_valid, resp_rdata,
//          resp_err.
// ----------------------------------------------------------------------------
interface mem_access_ctrl_if;
    import mem_access_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic                 req_byte;
    logic                 req_signed;
    logic [ADDR_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] req_wdata;
    logic                 resp_valid;
    logic [WORD_SIZE-1:0] resp_rdata;
    logic                 resp_err;

    modport master (
        output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_access_ctrl_byte_lane.sv
// ----------------------------------------------------------------------------
// byte_lane_unit
// Purely combinational byte-lane helper for the load/store controller.
//   i_word   : full memory word (big-endian lanes)
//   i_lane   : LANE_HI selects [15:8], LANE_LO selects [7:0]
//   i_signed : sign-extend the extracted byte (else zero-extend)
//   i_byte   : store byte to merge into the word
//   o_load   : extracted and extended byte
//   o_merged : i_word with the selected lane replaced by i_byte
// ----------------------------------------------------------------------------
module byte_lane_unit
    import mem_access_pkg::*;
(
    input  logic [WORD_SIZE-1:0] i_word,
    input  logic                 i_lane,
    input  logic                 i_signed,
    input  logic [BYTE_SIZE-1:0] i_byte,
    output logic [WORD_SIZE-1:0] o_load,
    output logic [WORD_SIZE-1:0] o_merged
);

    logic [BYTE_SIZE-1:0] w_sel;

    assign w_sel    = (i_lane == LANE_HI) ? i_word[15:8] : i_word[7:0];
    assign o_load   = {{(WORD_SIZE-BYTE_SIZE){i_signed & w_sel[BYTE_SIZE-1]}}, w_sel};
    assign o_merged = (i_lane == LANE_HI) ? {i_byte, i_word[7:0]}
                                          : {i_word[15:8], i_byte};

endmodule

// File: rtl/mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl
// Load/store controller between the CPU MEM stage and a 16-bit word memory
// with asynchronous read and synchronous write. Byte stores are done as
// read-modify-write; loads return sign/zero-extended data as a one-cycle
// response pulse.
//   clk, rst     : clock, synchronous active-high reset
//   req_bus      : pipeline request/response (mem_access_ctrl_if.slave)
//   mem_address  : word address to memory ({1'b0, addr[15:1]})
//   mem_wdata    : write data to memory
//   mem_write    : write strobe, memory commits on the rising edge
//   mem_rdata    : combinational read data from memory
// ----------------------------------------------------------------------------
module mem_access_ctrl
    import mem_access_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    mem_access_ctrl_if.slave      req_bus,
    output logic [ADDR_SIZE-1:0]  mem_address,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    output logic                  mem_write,
    input  logic [WORD_SIZE-1:0]  mem_rdata
);

    state_t               r_state;
    state_t               w_next_state;
    req_t                 r_req;
    logic [ADDR_SIZE-1:0] r_mem_address;
    logic [WORD_SIZE-1:0] r_mem_wdata;
    logic [WORD_SIZE-1:0] r_resp_rdata;
    logic                 r_resp_err;

    logic                 w_accept;
    logic                 w_misaligned;
    logic [WORD_SIZE-1:0] w_load_byte;
    logic [WORD_SIZE-1:0] w_merged;

    byte_lane_unit u_byte_lane (
        .i_word   (mem_rdata),
        .i_lane   (r_req.lane),
        .i_signed (r_req.is_signed),
        .i_byte   (r_req.wbyte),
        .o_load   (w_load_byte),
        .o_merged (w_merged)
    );

    // Ready is masked by rst so nothing can be taken during the reset cycle.
    assign req_bus.req_ready  = (r_state == ST_IDLE) && !rst;
    assign w_accept           = req_bus.req_valid && req_bus.req_ready;
    assign w_misaligned       = !req_bus.req_byte && req_bus.req_addr[0];

    assign req_bus.resp_valid = (r_state == ST_RESP);
    assign req_bus.resp_rdata = r_resp_rdata;
    assign req_bus.resp_err   = r_resp_err;

    // The strobe is gated by rst directly so a reset landing in WRITE
    // suppresses the commit on that same edge.
    assign mem_write   = (r_state == ST_WRITE) && !rst;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;

    // NOTE: every signal assigned in an always_comb gets a default first so
    // that no path through the case leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_misaligned)
                        w_next_state = ST_RESP;
                    else if (req_bus.req_write && !req_bus.req_byte)
                        w_next_state = ST_WRITE;
                    else
                        w_next_state = ST_READ;
                end
            end
            ST_READ:  w_next_state = r_req.is_write ? ST_WRITE : ST_RESP;
            ST_WRITE: w_next_state = ST_RESP;
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_req         <= '0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_resp_rdata  <= '0;
            r_resp_err    <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_accept) begin
                r_req.is_write  <= req_bus.req_write;
                r_req.is_byte   <= req_bus.req_byte;
                r_req.is_signed <= req_bus.req_signed;
                r_req.lane      <= req_bus.req_addr[0];
                r_req.wbyte     <= req_bus.req_wdata[BYTE_SIZE-1:0];
                r_resp_err      <= w_misaligned;
                r_resp_rdata    <= '0;
                // A misaligned request never touches memory, so the word
                // address keeps showing the previous access.
                if (!w_misaligned)
                    r_mem_address <= {1'b0, req_bus.req_addr[ADDR_SIZE-1:1]};
                if (req_bus.req_write && !req_bus.req_byte)
                    r_mem_wdata <= req_bus.req_wdata;
            end

            if (r_state == ST_READ) begin
                if (r_req.is_write)
                    r_mem_wdata <= w_merged;
                else
                    r_resp_rdata <= r_req.is_byte ? w_load_byte : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl with a behavioural word memory
// (asynchronous read, synchronous write).
// ----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_write;
    logic [15:0] mem_rdata;

    mem_access_ctrl_if bus ();

    mem_access_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_bus     (bus.slave),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_write   (mem_write),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory model with a preload path for setting up test words.
    logic [15:0] mem [0:32767];
    int          wr_count;
    logic        pl_en;
    logic [14:0] pl_addr;
    logic [15:0] pl_data;

    assign mem_rdata = mem[mem_address[14:0]];

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_address[14:0]] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
        if (pl_en)
            mem[pl_addr] <= pl_data;
    end

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [14:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Per-cycle record after the acceptance edge (index k = cycle T+k).
    logic        rec_mw [1:5];
    logic [15:0] rec_ma [1:5];
    logic [15:0] rec_md [1:5];
    int          lat;
    int          n_resp;
    logic [15:0] got_rd;
    logic        got_err;

    task automatic run_req(input logic w, input logic b, input logic s,
                           input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_byte   = b;
        bus.req_signed = s;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        check("ready_before_req", bus.req_ready, 1'b1);
        @(posedge clk);
        #1;
        // Scramble the fields after acceptance: the DUT must use its copy.
        bus.req_valid  = 1'b0;
        bus.req_write  = ~w;
        bus.req_byte   = ~b;
        bus.req_signed = ~s;
        bus.req_addr   = ~a;
        bus.req_wdata  = ~d;
        lat     = 0;
        n_resp  = 0;
        got_rd  = 16'hxxxx;
        got_err = 1'bx;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            rec_mw[k] = mem_write;
            rec_ma[k] = mem_address;
            rec_md[k] = mem_wdata;
            if (bus.resp_valid) begin
                n_resp++;
                if (lat == 0) begin
                    lat     = k;
                    got_rd  = bus.resp_rdata;
                    got_err = bus.resp_err;
                end
            end
        end
        check("resp_pulse_count", n_resp, 1);
    endtask

    typedef struct {
        logic        w;
        logic        b;
        logic        s;
        logic [15:0] a;
    } b2b_req_t;

    b2b_req_t    q [0:2];
    logic [15:0] b2b_got [0:7];
    int          b2b_n;
    int          accepts;
    int          viol;
    int          wc0;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        wr_count = 0;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_byte   = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready",      bus.req_ready,  1'b1);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_resp_rdata", bus.resp_rdata, 16'h0000);
        check("rst_resp_err",   bus.resp_err,   1'b0);
        check("rst_mem_write",  mem_write,      1'b0);
        check("rst_mem_addr",   mem_address,    16'h0000);
        check("rst_mem_wdata",  mem_wdata,      16'h0000);

        // Halfword store 0xBEEF @0x0010, then load it back
        run_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF);
        check("hst_mw_t1",   rec_mw[1], 1'b1);
        check("hst_ma_t1",   rec_ma[1], 16'h0008);
        check("hst_md_t1",   rec_md[1], 16'hBEEF);
        check("hst_lat",     lat,       2);
        check("hst_rdata",   got_rd,    16'h0000);
        check("hst_err",     got_err,   1'b0);
        check("hst_mem",     mem[15'h0008], 16'hBEEF);
        run_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        check("hld_mw_t1",   rec_mw[1], 1'b0);
        check("hld_lat",     lat,       2);
        check("hld_rdata",   got_rd,    16'hBEEF);

        // Byte loads from word 0x0008 = 0x12F4
        preload(15'h0008, 16'h12F4);
        run_req(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000);
        check("bld_s_lo_lat",   lat,    2);
        check("bld_s_lo_rdata", got_rd, 16'hFFF4);
        run_req(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000);
        check("bld_u_lo_rdata", got_rd, 16'h00F4);
        run_req(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000);
        check("bld_s_hi_rdata", got_rd, 16'h0012);

        // Address wrap: 0xFFFF -> word 0x7FFF low lane
        preload(15'h7FFF, 16'hA5C3);
        run_req(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000);
        check("wrap_ma",       rec_ma[1], 16'h7FFF);
        check("wrap_lo_rdata", got_rd,    16'hFFC3);
        run_req(1'b0, 1'b1, 1'b1, 16'hFFFE, 16'h0000);
        check("wrap_hi_rdata", got_rd,    16'hFFA5);

        // Byte store read-modify-write
        preload(15'h0008, 16'h1234);
        run_req(1'b1, 1'b1, 1'b0, 16'h0011, 16'h77AB);
        check("bst_mw_t1", rec_mw[1], 1'b0);
        check("bst_ma_t1", rec_ma[1], 16'h0008);
        check("bst_mw_t2", rec_mw[2], 1'b1);
        check("bst_md_t2", rec_md[2], 16'h12AB);
        check("bst_lat",   lat,       3);
        check("bst_rdata", got_rd,    16'h0000);
        check("bst_mem",   mem[15'h0008], 16'h12AB);
        run_req(1'b1, 1'b1, 1'b0, 16'h0010, 16'h00CD);
        check("bst_hi_md_t2", rec_md[2], 16'hCDAB);
        check("bst_hi_mem",   mem[15'h0008], 16'hCDAB);

        // Misaligned halfword accesses: error response, no memory write
        wc0 = wr_count;
        run_req(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000);
        check("mis_ld_lat",   lat,     1);
        check("mis_ld_err",   got_err, 1'b1);
        check("mis_ld_rdata", got_rd,  16'h0000);
        check("mis_ld_ma",    rec_ma[1], 16'h0008);
        run_req(1'b1, 1'b0, 1'b0, 16'h0005, 16'h5A5A);
        check("mis_st_lat",   lat,     1);
        check("mis_st_err",   got_err, 1'b1);
        check("mis_no_write", wr_count, wc0);

        // Error flag clears on the next good request
        run_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        check("err_clear", got_err, 1'b0);

        // Reset during the WRITE cycle of a byte store
        preload(15'h0040, 16'h5566);
        wc0 = wr_count;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_byte  = 1'b1;
        bus.req_signed = 1'b0;
        bus.req_addr  = 16'h0081;
        bus.req_wdata = 16'h0099;
        @(posedge clk);              // acceptance edge T
        #1 bus.req_valid = 1'b0;
        @(posedge clk);              // edge T+1: READ -> WRITE
        #1 rst = 1'b1;
        @(negedge clk);
        check("rstw_mem_write", mem_write, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstw_ready", bus.req_ready, 1'b1);
        n_resp = 0;
        if (bus.resp_valid) n_resp++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.resp_valid) n_resp++;
        end
        check("rstw_no_resp", n_resp, 0);
        check("rstw_mem",     mem[15'h0040], 16'h5566);
        check("rstw_no_write", wr_count, wc0);

        // Back-to-back with req_valid held high
        preload(15'h0010, 16'h1111);
        preload(15'h0011, 16'h2280);
        preload(15'h0012, 16'h3333);
        q[0] = '{w: 1'b0, b: 1'b0, s: 1'b0, a: 16'h0020};
        q[1] = '{w: 1'b0, b: 1'b1, s: 1'b0, a: 16'h0023};
        q[2] = '{w: 1'b0, b: 1'b0, s: 1'b0, a: 16'h0024};
        b2b_n   = 0;
        accepts = 0;
        viol    = 0;
        begin
            int  idx;
            int  busy;
            logic acc;
            idx  = 0;
            busy = 0;
            @(negedge clk);
            bus.req_valid  = 1'b1;
            bus.req_write  = q[0].w;
            bus.req_byte   = q[0].b;
            bus.req_signed = q[0].s;
            bus.req_addr   = q[0].a;
            bus.req_wdata  = 16'h0000;
            for (int cyc = 0; cyc < 20; cyc++) begin
                if (cyc != 0) @(negedge clk);
                if (busy != 0 && bus.req_ready) viol++;
                if (bus.resp_valid) begin
                    if (b2b_n < 8) b2b_got[b2b_n] = bus.resp_rdata;
                    b2b_n++;
                    busy = 0;
                end
                acc = bus.req_valid && bus.req_ready;
                @(posedge clk);
                if (acc) begin
                    accepts++;
                    busy = 1;
                    idx++;
                end
                #1;
                if (idx < 3) begin
                    bus.req_write  = q[idx].w;
                    bus.req_byte   = q[idx].b;
                    bus.req_signed = q[idx].s;
                    bus.req_addr   = q[idx].a;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
        end
        check("b2b_accepts",   accepts, 3);
        check("b2b_ready_low", viol,    0);
        check("b2b_resp_cnt",  b2b_n,   3);
        check("b2b_resp0",     b2b_got[0], 16'h1111);
        check("b2b_resp1",     b2b_got[1], 16'h0080);
        check("b2b_resp2",     b2b_got[2], 16'h3333);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store controller between the CPU MEM stage and the 16-bit word memory unit. Accepts byte-addressed load/store requests from the pipeline over a valid/ready handshake. Translates them into word accesses on the memory's asynchronous-read / synchronous-write port, including read-modify-write for byte stores. Returns load data, sign- or zero-extended, as a one-cycle response pulse.

## Interface
- WORD_SIZE, 16, memory word and data width
- ADDR_SIZE, 16, byte-address width from pipeline and word-address width to memory
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  pipeline presents a request
- req_ready  out  1  controller can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_byte  in  1  1 = byte access, 0 = halfword (16-bit) access
- req_signed  in  1  loads only: 1 = sign-extend byte, 0 = zero-extend
- req_addr  in  ADDR_SIZE  byte address
- req_wdata  in  WORD_SIZE  store data; byte stores use bits [7:0]
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  WORD_SIZE  load result, valid with resp_valid; 0 for stores
- resp_err  out  1  misaligned halfword, valid with resp_valid
- mem_address  out  ADDR_SIZE  word address to memory: {1'b0, addr[15:1]}
- mem_wdata  out  WORD_SIZE  to memory data_in
- mem_write  out  1  to memory write; memory commits on the rising edge while high
- mem_rdata  in  WORD_SIZE  from memory data_out (combinational read)

## Operation
- States: IDLE, READ, WRITE, RESP.
- Handshake: a request is accepted when req_valid && req_ready. All request fields are latched on acceptance. The request inputs are ignored otherwise.
- Byte order is big-endian within a word:
  - addr[0]=0 selects bits [15:8].
  - addr[0]=1 selects bits [7:0].
- Halfword with addr[0]=1: IDLE→RESP. No memory access. resp_err=1, resp_rdata=0.
- Halfword load: IDLE→READ→RESP. In READ, mem_address is driven and mem_rdata is captured whole.
- Halfword store: IDLE→WRITE→RESP. mem_wdata=req_wdata, mem_write=1 in WRITE.
- Byte load: IDLE→READ→RESP. The selected byte is extracted, then extended per req_signed.
- Byte store: IDLE→READ→WRITE→RESP.
  - READ captures the full word.
  - WRITE writes the merged word: selected lane = wdata[7:0], other lane unchanged.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- mem_write is high only in WRITE and is gated low by rst in the same cycle.
- mem_address holds the last word address outside active states.

## Timing
- Acceptance edge = T.
- Response latency (resp_valid high in the cycle after):
  - misaligned: T+1
  - halfword load/store and byte load: T+2
  - byte store: T+3
- Memory write commits on the edge ending the WRITE cycle.
- req_ready is low from T until the cycle after RESP. Back-to-back throughput is one request per latency+1 cycles.
- Reset values: state IDLE, req_ready=1 after reset release, resp_valid=0, resp_rdata=0, resp_err=0, mem_write=0, mem_address=0, mem_wdata=0.
- Reset mid-operation aborts the operation:
  - no write is issued during or after the reset cycle;
  - no resp_valid for the aborted request.
- Address wrap: byte address 0xFFFF maps to word 0x7FFF, low lane. There is no carry beyond 16 bits.

## Structure
- Shared package mem_access_pkg holds:
  - state encoding constants (IDLE/READ/WRITE/RESP);
  - lane select constants (LANE_HI=0, LANE_LO=1).
- One sub-module, byte_lane_unit, purely combinational:
  - extract with sign/zero extend for loads;
  - merge of store byte into the captured word.
- The FSM and registers live in mem_access_ctrl.

## Test plan
- Reset, then halfword store 0xBEEF at addr 0x0010 → mem_write=1 at T+1 with mem_address 0x0008. resp_valid at T+2. A following halfword load of 0x0010 returns 0xBEEF.
- Word 0x0008 = 0x12F4:
  - signed byte load addr 0x0011 → 0xFFF4;
  - unsigned load → 0x00F4;
  - byte load addr 0x0010 → 0x0012.
- Word 0x0008 = 0x1234, byte store 0xAB at addr 0x0011 → READ at T+1, write 0x12AB at T+2, resp at T+3. Memory then holds 0x12AB.
- Halfword load at addr 0x0003 → resp_valid at T+1, resp_err=1, resp_rdata=0, and no mem_write at any time.
- rst asserted in the WRITE cycle of a byte store → memory word unchanged, no resp_valid. req_ready=1 the cycle after rst deasserts.
- req_valid held high continuously with 3 queued requests → req_ready low while busy. Each request is accepted exactly once, and responses arrive in order.
